ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
- Two-requester arbiter that shares the single-port 256x16 RAM between requester 0 (CPU fetch/load/store port) and requester 1 (program loader / debug port).
- Round-robin arbitration on each cycle, plus an optional lock for multi-cycle exclusive sequences.
- Drives the RAM's write enable, address and write data, and returns read data with a per-port valid strobe one cycle later.

Parameters:
ADDR_W, 8, RAM address width
DATA_W, 16, RAM data width

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
req0  input  1  requester 0 access request
we0  input  1  requester 0 write (1) / read (0)
lock0  input  1  requester 0 holds ownership after this access
addr0  input  ADDR_W  requester 0 address
wdata0  input  DATA_W  requester 0 write data
gnt0  output  1  requester 0 access accepted at this clock edge (combinational)
rvalid0  output  1  requester 0 read data valid (registered)
rdata0  output  DATA_W  requester 0 read data
req1, we1, lock1, addr1, wdata1, gnt1, rvalid1, rdata1: same definitions for requester 1
ram_w_en  output  1  RAM write enable
ram_addr  output  ADDR_W  RAM read/write address
ram_w_data  output  DATA_W  RAM write data
ram_r_data  input  DATA_W  RAM read data, registered; valid the cycle after the address is presented

Behaviour:
- Reset: rst_n sampled on posedge clk. On reset: state=IDLE, last_gnt=1 (requester 0 wins the first tie), rvalid0=rvalid1=0.
  - While rst_n=0, gnt0, gnt1 and ram_w_en are forced to 0.
  - Reset during a locked sequence or a pending read clears the lock and drops the pending rvalid.
- FSM states:
  - IDLE: no owner. Both req -> grant the port != last_gnt. One req -> grant it. None -> no grant.
  - OWN0: only port 0 can be granted; gnt1=0 even if req1=1.
  - OWN1: symmetric to OWN0.
- Transitions, evaluated at the edge:
  - Granted port x with lockx=1 -> OWNx.
  - In OWNx with lockx=0 -> IDLE. This holds whether or not x accesses in that cycle; x keeps exclusive grant during that final cycle.
  - In IDLE, a grant without lock -> stay in IDLE.
- last_gnt updates to x on every edge where gntx=1; otherwise it holds.
- gntx is combinational from req, state and last_gnt. At most one gnt is high per cycle, and gntx implies reqx.
- RAM drive:
  - Granted port x: ram_addr=addrx, ram_w_data=wdatax, ram_w_en=wex.
  - No grant: ram_w_en=0, ram_addr=addr0, ram_w_data=wdata0.
- Read latency: a read granted at edge t yields rvalidx=1 during cycle t+1, with rdatax=ram_r_data in that cycle.
  - rdata0 and rdata1 both carry ram_r_data unconditionally; the data is meaningful only with rvalid.
  - Writes never raise rvalid.
- Back-to-back accesses: one access per cycle. A read of an address written at the previous edge returns the new data; the arbiter does no forwarding.
- Requesters hold req/we/addr/wdata stable until they see gnt.
- Fairness: with no lock active, a continuously requesting port waits at most one cycle. A lock can starve the other port indefinitely; that is the owner's responsibility.

Test Plan:
- Reset, then req0=1 we0=0 addr0=8'h05 with RAM[5]=16'hBEEF -> gnt0=1 same cycle; rvalid0=1, rdata0=16'hBEEF next cycle; rvalid1=0.
- req0=req1=1 continuously, both reads, addr0=8'h10, addr1=8'h20, after reset -> grants alternate 0,1,0,1; ram_addr alternates 10,20; rvalid alternates with one-cycle lag.
- req1=1 we1=1 addr1=8'h30 wdata1=16'h1234, then req0 reads 8'h30 next cycle -> ram_w_en=1 in cycle 1; rdata0=16'h1234 with rvalid0=1 in cycle 3.
- lock0=1 for 3 granted reads while req1=1 throughout -> gnt1=0 for those 3 cycles; the cycle after the lock0=0 access, gnt1=1.
- Assert rst_n=0 during OWN1 with a read just granted -> next cycle rvalid1=0 and state IDLE; after release a tie is granted to port 0.
- No requests for 10 cycles -> ram_w_en=0, gnt0=gnt1=0, rvalid0=rvalid1=0 throughout.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one single-port RAM between two requesters.
//   Requester 0 (CPU fetch/load/store) and requester 1 (loader / debug) each
//   present req/we/lock/addr/wdata and get a combinational gnt back.
//   Read data comes back with a per-port rvalid one cycle after the grant.
//   ram_w_en / ram_addr / ram_w_data drive the RAM.
//   ram_r_data is the RAM's registered read data.
// Arbitration is round-robin on ties. A granted access with lock set makes
// that port the exclusive owner until it presents lock=0.
//
// Handshake: a requester holds req/we/addr/wdata stable until it sees gnt
// high. An access is performed at the clock edge where req and gnt are both
// high. rvalid pulses for exactly one cycle per granted read; writes return
// nothing.
module ram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    // requester 0
    input  logic              req0,
    input  logic              we0,
    input  logic              lock0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    // requester 1
    input  logic              req1,
    input  logic              we1,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    // RAM side
    output logic              ram_w_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_w_data,
    input  logic [DATA_W-1:0] ram_r_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_gnt_q, last_gnt_d;   // 1: port 1 was granted most recently
    logic   rvalid0_q, rvalid0_d;
    logic   rvalid1_q, rvalid1_d;

    // Grant decision
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                IDLE: begin
                    if (req0 && req1) begin
                        // tie goes to the port that did not win last time
                        gnt0 = last_gnt_q;
                        gnt1 = ~last_gnt_q;
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
                end
                OWN0:    gnt0 = req0;
                OWN1:    gnt1 = req1;
                default: ;
            endcase
        end
    end

    // Next state, round-robin pointer and read-valid pipeline
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        rvalid0_d  = gnt0 & ~we0;
        rvalid1_d  = gnt1 & ~we1;

        if (gnt0) last_gnt_d = 1'b0;
        if (gnt1) last_gnt_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (gnt0 && lock0)      state_d = OWN0;
                else if (gnt1 && lock1) state_d = OWN1;
            end
            // owner releases on lock=0 whether or not it accesses this cycle
            OWN0:    if (!lock0) state_d = IDLE;
            OWN1:    if (!lock1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
        end
    end

    // RAM drive: port 1 only when granted, otherwise port 0's bus is passed
    // through so the idle address is stable.
    always_comb begin
        ram_addr   = addr0;
        ram_w_data = wdata0;
        ram_w_en   = gnt0 & we0;
        if (gnt1) begin
            ram_addr   = addr1;
            ram_w_data = wdata1;
            ram_w_en   = we1;
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    // read data is shared; it is meaningful only alongside rvalid
    assign rdata0  = ram_r_data;
    assign rdata1  = ram_r_data;

endmodule
